// File: rtl/sync_tx_sequencer.sv
// Source-side sequencer for the enable-based CDC synchronizer: buffers words,
// settles each on tx_data, pulses tx_en for EN_CYCLES, then holds for GUARD_CYCLES.
module sync_tx_sequencer #(
  parameter int DATA_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int EN_CYCLES    = 3,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_en,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (EN_CYCLES > GUARD_CYCLES) ? EN_CYCLES : GUARD_CYCLES;
  localparam int CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);

  localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT1_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ASSERT, GUARD} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  full, empty, push, pop;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tx_en_q, tx_en_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  // in_ready looks only at the registered count, so a pop cannot free a slot
  // for a push in the same cycle.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT1_ONE;
      2'b01:   count_d = count_q - CNT1_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Pop reads the registered occupancy, so a fresh word waits one cycle (no bypass).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = EN_LOAD;
        tx_en_d = 1'b1;
        state_d = ASSERT;
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          tx_en_d = 1'b0;
          cnt_d   = GUARD_LOAD;
          state_d = GUARD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GUARD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign fifo_count = count_q;
  assign busy       = !rst && ((state_q != IDLE) || !empty);

endmodule

// File: tb/tb_sync_tx_sequencer.sv
// Scoreboard bench for sync_tx_sequencer: a schedule model predicts when each
// accepted word is popped, pulsed and retired; a monitor checks every enable pulse.
module tb_sync_tx_sequencer;
  localparam int DW = 4, DEPTH = 4, EN = 3, GUARD = 4;
  localparam int PERIOD = 2 + EN + GUARD;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b1;
  logic in_ready, tx_en, busy;
  logic [DW-1:0] in_data = 4'hF;
  logic [DW-1:0] tx_data;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct {
    logic [DW-1:0] d;
    int            push_e;
    int            pop_e;
  } wrec_t;

  wrec_t hist[$];
  wrec_t sb[$];
  int tests = 0, fails = 0, edge_n = 0, next_free = 0;

  sync_tx_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .EN_CYCLES(EN), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tx_data(tx_data), .tx_en(tx_en), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, edge_n, act, exp);
    end
  endtask

  // Reference model: a word pushed at edge p pops at max(p+1, previous pop + PERIOD);
  // tx_en is high after edges pop+1..pop+EN; the block is busy until pop+PERIOD-2.
  initial begin
    logic cap_rst, cap_push;
    logic [DW-1:0] cap_d, dat;
    int cnt;
    logic bsy, en;
    wrec_t w;
    cap_rst = 1'b1; cap_push = 1'b0; cap_d = '0;
    forever begin
      @(negedge clk);
      if (cap_rst) begin
        hist.delete(); sb.delete(); next_free = 0;
      end else if (cap_push) begin
        w.d = cap_d; w.push_e = edge_n;
        w.pop_e = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
        next_free = w.pop_e + PERIOD;
        hist.push_back(w); sb.push_back(w);
      end
      cnt = 0; bsy = 1'b0; en = 1'b0; dat = '0;
      foreach (hist[i]) begin
        if (hist[i].push_e <= edge_n && edge_n < hist[i].pop_e) cnt++;
        if (hist[i].push_e <= edge_n && edge_n <= hist[i].pop_e + PERIOD - 2) bsy = 1'b1;
        if (edge_n >= hist[i].pop_e + 1 && edge_n <= hist[i].pop_e + EN) en = 1'b1;
        if (hist[i].pop_e <= edge_n) dat = hist[i].d;
      end
      chk("fifo_count", 32'(fifo_count), cnt);
      chk("in_ready", 32'(in_ready), 32'((cnt < DEPTH) && !rst));
      chk("busy", 32'(busy), 32'(bsy && !rst));
      chk("tx_en", 32'(tx_en), 32'(en));
      chk("tx_data", 32'(tx_data), 32'(dat));
      cap_rst  = rst;
      cap_push = in_valid && (cnt < DEPTH) && !rst;
      cap_d    = in_data;
    end
  end

  // Monitor: each rising tx_en must carry the next scoreboard word at its predicted edge.
  initial begin
    logic prev;
    wrec_t w;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1 && prev !== 1'b1) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pulse edge=%0d got data=%0h exp no pulse", edge_n, tx_data);
        end else begin
          w = sb.pop_front();
          chk("pulse_data", 32'(tx_data), 32'(w.d));
          chk("pulse_edge", edge_n, w.pop_e + 1);
        end
      end
      prev = tx_en;
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int t;
    logic acc;
    t = 0; acc = 1'b0;
    in_valid = 1'b1; in_data = d;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; t++;
    end while (!acc && t < 200);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout got in_ready=0 exp accept of %0h", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((busy !== 1'b0 || tx_en !== 1'b0) && t < 1000) begin
      @(negedge clk); t++;
    end
    if (t >= 1000) begin
      tests++; fails++;
      $display("FAIL drain_timeout got busy=%b exp 0", busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int gap, t;
    // reset held 3 cycles with in_valid asserted
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    send(4'hA); drain();
    send(4'h1); send(4'h2); send(4'h3); drain();
    for (int i = 0; i < 8; i++) send(4'(i));
    drain();

    for (int k = 0; k < 30; k++) begin
      gap = $urandom_range(0, 10);
      repeat (gap) begin @(posedge clk); #1; end
      send(4'($urandom));
    end
    drain();

    // reset during the second ASSERT cycle with a word still queued
    send(4'h7); send(4'h9);
    t = 0;
    while (tx_en !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      tests++; fails++;
      $display("FAIL midreset_wait got tx_en=%b exp 1", tx_en);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    send(4'h5); drain();

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
